// File: rtl/exception_entry_sequencer.sv
// Exception/interrupt entry sequencer: records cause, EPC and bad address, then flushes,
// saves, reads the vector table and redirects the PC. Also executes ERET.
module exception_entry_sequencer #(
  parameter logic [31:0] VEC_BASE = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [2:0]  trigger,
  input  logic [31:0] pc_in,
  input  logic [31:0] addr_in,
  input  logic [4:0]  sys_num,
  input  logic        irq,
  input  logic [3:0]  irq_id,
  input  logic        eret,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        flush,
  output logic        pc_load,
  output logic [31:0] pc_next,
  output logic [31:0] epc,
  output logic [2:0]  ecause,
  output logic [31:0] ebadaddr,
  output logic        ie,
  output logic        halted
);

  typedef enum logic [2:0] {StIdle, StSave, StVector, StRedirect, StHalt} state_e;

  localparam logic [2:0] CauseInsta = 3'd1;
  localparam logic [2:0] CauseDataa = 3'd2;
  localparam logic [2:0] CauseSys   = 3'd4;
  localparam logic [2:0] CauseUnk   = 3'd5;
  localparam logic [2:0] CauseIrq   = 3'd6;

  state_e      state_q;
  logic [2:0]  cause_q;
  logic [31:0] pc_lat_q;
  logic [31:0] addr_lat_q;
  logic [5:0]  index_q;
  logic [31:0] epc_q;
  logic [2:0]  ecause_q;
  logic [31:0] ebadaddr_q;
  logic [31:0] pc_next_q;
  logic        ie_q;
  logic        eie_q;
  logic        flush_q;
  logic        eret_load_q;

  // Reserved codes 6-7 behave exactly like "no trigger".
  logic trig_valid;
  assign trig_valid = (trigger >= CauseInsta) && (trigger <= CauseUnk);

  logic unused_rdata;
  assign unused_rdata = ^mem_rdata[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cause_q     <= 3'd0;
      pc_lat_q    <= 32'd0;
      addr_lat_q  <= 32'd0;
      index_q     <= 6'd0;
      epc_q       <= 32'd0;
      ecause_q    <= 3'd0;
      ebadaddr_q  <= 32'd0;
      pc_next_q   <= 32'd0;
      ie_q        <= 1'b1;
      eie_q       <= 1'b0;
      flush_q     <= 1'b0;
      eret_load_q <= 1'b0;
    end else begin
      flush_q     <= 1'b0;
      eret_load_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (enable) begin
            if (trig_valid) begin
              cause_q    <= trigger;
              pc_lat_q   <= pc_in;
              addr_lat_q <= (trigger == CauseInsta || trigger == CauseDataa) ? addr_in : 32'd0;
              index_q    <= (trigger == CauseSys) ? 6'd32 + {1'b0, sys_num} : {3'd0, trigger};
              flush_q    <= 1'b1;
              state_q    <= StSave;
            end else if (irq && ie_q) begin
              cause_q    <= CauseIrq;
              pc_lat_q   <= pc_in;
              addr_lat_q <= 32'd0;
              index_q    <= 6'd16 + {2'd0, irq_id};
              flush_q    <= 1'b1;
              state_q    <= StSave;
            end else if (eret) begin
              pc_next_q   <= epc_q;
              ie_q        <= eie_q;
              eret_load_q <= 1'b1;
            end
          end
        end
        StSave: begin
          // First fault's context is committed even if a second fault arrives now.
          epc_q      <= pc_lat_q;
          ecause_q   <= cause_q;
          ebadaddr_q <= addr_lat_q;
          eie_q      <= ie_q;
          ie_q       <= 1'b0;
          state_q    <= trig_valid ? StHalt : StVector;
        end
        StVector: begin
          if (trig_valid) begin
            state_q <= StHalt;
          end else if (mem_ack) begin
            pc_next_q <= {mem_rdata[31:2], 2'b00};
            state_q   <= StRedirect;
          end
        end
        StRedirect: state_q <= StIdle;
        StHalt:     state_q <= StHalt;
        default:    state_q <= StIdle;
      endcase
    end
  end

  assign mem_req  = (state_q == StVector);
  assign mem_addr = mem_req ? VEC_BASE + {24'd0, index_q, 2'b00} : 32'd0;
  assign busy     = (state_q != StIdle);
  assign flush    = flush_q;
  assign pc_load  = (state_q == StRedirect) || eret_load_q;
  assign pc_next  = pc_next_q;
  assign epc      = epc_q;
  assign ecause   = ecause_q;
  assign ebadaddr = ebadaddr_q;
  assign ie       = ie_q;
  assign halted   = (state_q == StHalt);

endmodule

// File: tb/tb_exception_entry_sequencer.sv
// Directed table-driven bench for exception_entry_sequencer plus hand-written corner cases.
module tb_exception_entry_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [2:0]  trigger;
  logic [31:0] pc_in;
  logic [31:0] addr_in;
  logic [4:0]  sys_num;
  logic        irq;
  logic [3:0]  irq_id;
  logic        eret;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        flush;
  logic        pc_load;
  logic [31:0] pc_next;
  logic [31:0] epc;
  logic [2:0]  ecause;
  logic [31:0] ebadaddr;
  logic        ie;
  logic        halted;

  exception_entry_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .trigger   (trigger),
    .pc_in     (pc_in),
    .addr_in   (addr_in),
    .sys_num   (sys_num),
    .irq       (irq),
    .irq_id    (irq_id),
    .eret      (eret),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .flush     (flush),
    .pc_load   (pc_load),
    .pc_next   (pc_next),
    .epc       (epc),
    .ecause    (ecause),
    .ebadaddr  (ebadaddr),
    .ie        (ie),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  // Inputs for one cycle, and the outputs expected just after the following edge.
  typedef struct {
    logic        rst;
    logic        en;
    logic [2:0]  trig;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [4:0]  sys;
    logic        irq;
    logic [3:0]  id;
    logic        eret;
    logic        ack;
    logic [31:0] rdata;
    logic [5:0]  flags;  // {busy, flush, pc_load, mem_req, halted, ie}
    logic [31:0] maddr;
    logic [31:0] pcn;
    logic [31:0] epc;
    logic [2:0]  ec;
    logic [31:0] eb;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(logic rst, logic en, logic [2:0] trig, logic [31:0] pc,
                              logic [31:0] addr, logic [4:0] sys, logic irqv, logic [3:0] id,
                              logic er, logic ack, logic [31:0] rdata, logic [5:0] flags,
                              logic [31:0] maddr, logic [31:0] pcn, logic [31:0] e_pc,
                              logic [2:0] ec, logic [31:0] eb);
    vec_t v;
    v.rst = rst; v.en = en; v.trig = trig; v.pc = pc; v.addr = addr; v.sys = sys;
    v.irq = irqv; v.id = id; v.eret = er; v.ack = ack; v.rdata = rdata; v.flags = flags;
    v.maddr = maddr; v.pcn = pcn; v.epc = e_pc; v.ec = ec; v.eb = eb;
    return v;
  endfunction

  task automatic drive_idle();
    enable = 1'b1; trigger = 3'd0; pc_in = 32'd0; addr_in = 32'd0; sys_num = 5'd0;
    irq = 1'b0; irq_id = 4'd0; eret = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
  endtask

  task automatic check1(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    // en trig pc addr sys irq id eret ack rdata | flags maddr pc_next epc ecause ebadaddr
    vq.push_back(mk(0,0,1,32'h500,32'h0,0,0,0,0,0,0,      6'b000001,0,0,0,0,0));
    // DATAA
    vq.push_back(mk(0,1,2,32'h400,32'h1003,0,0,0,0,0,0,   6'b110001,0,0,0,0,0));
    vq.push_back(mk(0,1,0,0,0,0,0,0,0,0,0,                6'b100100,32'h108,0,32'h400,2,32'h1003));
    vq.push_back(mk(0,1,0,0,0,0,0,0,0,1,32'h2002,         6'b101000,0,32'h2000,32'h400,2,32'h1003));
    vq.push_back(mk(0,1,0,0,0,0,0,0,0,0,0,                6'b000000,0,32'h2000,32'h400,2,32'h1003));
    // SYS with three ack wait states; index 32+5
    vq.push_back(mk(0,1,4,32'h600,32'hdead,5,0,0,0,0,0,   6'b110000,0,32'h2000,32'h400,2,32'h1003));
    vq.push_back(mk(0,1,0,0,0,0,0,0,0,0,0,                6'b100100,32'h194,32'h2000,32'h600,4,0));
    vq.push_back(mk(0,1,0,0,0,0,0,0,0,0,0,                6'b100100,32'h194,32'h2000,32'h600,4,0));
    vq.push_back(mk(0,1,0,0,0,0,0,0,0,0,0,                6'b100100,32'h194,32'h2000,32'h600,4,0));
    vq.push_back(mk(0,1,0,0,0,0,0,0,0,0,0,                6'b100100,32'h194,32'h2000,32'h600,4,0));
    vq.push_back(mk(0,1,0,0,0,0,0,0,0,1,32'h3001,         6'b101000,0,32'h3000,32'h600,4,0));
    vq.push_back(mk(0,1,0,0,0,0,0,0,0,0,0,                6'b000000,0,32'h3000,32'h600,4,0));
    // IRQ while ie=0: ignored; ERET restores the (zero) saved enable
    vq.push_back(mk(0,1,0,32'h650,0,0,1,3,0,0,0,          6'b000000,0,32'h3000,32'h600,4,0));
    vq.push_back(mk(0,1,0,0,0,0,0,0,1,0,0,                6'b001000,0,32'h600,32'h600,4,0));
    vq.push_back(mk(0,1,0,0,0,0,0,0,0,0,0,                6'b000000,0,32'h600,32'h600,4,0));
    vq.push_back(mk(1,1,0,0,0,0,0,0,0,0,0,                6'b000001,0,0,0,0,0));
    // IRQ 3 with ie=1, then ERET
    vq.push_back(mk(0,1,0,32'h700,32'h55,0,1,3,0,0,0,     6'b110001,0,0,0,0,0));
    vq.push_back(mk(0,1,0,0,0,0,0,0,0,0,0,                6'b100100,32'h14c,0,32'h700,6,0));
    vq.push_back(mk(0,1,0,0,0,0,0,0,0,1,32'h4000,         6'b101000,0,32'h4000,32'h700,6,0));
    vq.push_back(mk(0,1,0,0,0,0,0,0,0,0,0,                6'b000000,0,32'h4000,32'h700,6,0));
    vq.push_back(mk(0,1,0,0,0,0,0,0,1,0,0,                6'b001001,0,32'h700,32'h700,6,0));
    vq.push_back(mk(0,1,0,0,0,0,0,0,0,0,0,                6'b000001,0,32'h700,32'h700,6,0));
    // BREAK beats irq and eret; then UNK in VECTOR double-faults
    vq.push_back(mk(0,1,3,32'h800,32'h9,0,1,2,1,0,0,      6'b110001,0,32'h700,32'h700,6,0));
    vq.push_back(mk(0,1,0,0,0,0,0,0,0,0,0,                6'b100100,32'h10c,32'h700,32'h800,3,0));
    vq.push_back(mk(0,1,5,32'h900,32'h77,0,0,0,0,0,0,     6'b100010,0,32'h700,32'h800,3,0));
    vq.push_back(mk(0,1,0,0,0,0,0,0,0,1,32'h5000,         6'b100010,0,32'h700,32'h800,3,0));
    vq.push_back(mk(1,1,0,0,0,0,0,0,0,0,0,                6'b000001,0,0,0,0,0));
    // Reserved trigger code ignored
    vq.push_back(mk(0,1,6,32'ha00,32'h1,0,0,0,0,0,0,      6'b000001,0,0,0,0,0));

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    foreach (vq[i]) begin
      vec_t v;
      logic [136:0] act, exp;
      v = vq[i];
      reset = v.rst; enable = v.en; trigger = v.trig; pc_in = v.pc; addr_in = v.addr;
      sys_num = v.sys; irq = v.irq; irq_id = v.id; eret = v.eret; mem_ack = v.ack;
      mem_rdata = v.rdata;
      @(posedge clk);
      #1;
      act = {busy, flush, pc_load, mem_req, halted, ie, mem_addr, pc_next, epc, ecause, ebadaddr};
      exp = {v.flags, v.maddr, v.pcn, v.epc, v.ec, v.eb};
      n_vec++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL vec%0d: got flags=%b maddr=%h pcn=%h epc=%h ec=%0d eb=%h want flags=%b maddr=%h pcn=%h epc=%h ec=%0d eb=%h",
                 i, act[136:131], mem_addr, pc_next, epc, ecause, ebadaddr,
                 v.flags, v.maddr, v.pcn, v.epc, v.ec, v.eb);
      end
    end

    // Asynchronous reset in VECTOR: mem_req must drop before the next clock edge.
    reset = 1'b0;
    drive_idle();
    trigger = 3'd1; pc_in = 32'hb00; addr_in = 32'h44;
    @(posedge clk); #1 drive_idle();
    @(posedge clk); #1;
    check1("vector_req", {31'd0, mem_req}, 32'd1);
    check1("vector_addr", mem_addr, 32'h104);
    #2 reset = 1'b1;
    #1;
    check1("async_req", {31'd0, mem_req}, 32'd0);
    check1("async_busy_ie", {30'd0, busy, ie}, 32'd1);
    check1("async_epc", epc, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Latency: with ack held high, pc_load appears two edges after the sampling edge.
    begin
      int cyc;
      drive_idle();
      mem_ack = 1'b1; mem_rdata = 32'hc00;
      trigger = 3'd2; pc_in = 32'hc40; addr_in = 32'h8;
      @(posedge clk); #1 trigger = 3'd0;
      cyc = 0;
      while (!pc_load && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
      end
      check1("latency", cyc, 32'd2);
      check1("latency_pcn", pc_next, 32'hc00);
      drive_idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
